// File: rtl/fpu_div_seq.sv
// Iterative IEEE-754 divider: one restoring-division quotient bit per cycle,
// five RISC-V rounding modes, fflags {NV,DZ,OF,UF,NX}, valid/ready on both sides.
module fpu_div_seq #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [2:0]   rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   flags,
  output logic         busy
);

  localparam int MW   = FRAC_W + 1;
  localparam int QW   = FRAC_W + 3;
  localparam int RW   = FRAC_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int LW   = $clog2(MW + 1);
  localparam int CW   = $clog2(QW + 1);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  logic [2:0]             state;
  logic [W-1:0]           a_reg, b_reg;
  logic [2:0]             rm_reg;
  logic                   sign_reg;
  logic signed [EW-1:0]   exp_reg;
  logic [MW-1:0]          mb_reg;
  logic [RW-1:0]          rem_reg;
  logic [QW-1:0]          q_reg;
  logic [CW-1:0]          cnt_reg;
  logic [W-1:0]           result_reg;
  logic [4:0]             flags_reg;

  function automatic logic [LW-1:0] lzc(input logic [MW-1:0] m);
    logic [LW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + LW'(1);
      end
    end
    return n;
  endfunction

  // Operand unpack: subnormals are normalised so both mantissas land in [1,2).
  logic [W-1:0]         opd     [2];
  logic                 sgn     [2];
  logic [EXP_W-1:0]     e_raw   [2];
  logic [FRAC_W-1:0]    f_raw   [2];
  logic                 is_zero [2];
  logic                 is_inf  [2];
  logic                 is_nan  [2];
  logic                 is_snan [2];
  logic [LW-1:0]        lz      [2];
  logic [MW-1:0]        m_norm  [2];
  logic signed [EW-1:0] e_eff   [2];

  assign opd[0] = a_reg;
  assign opd[1] = b_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      logic [MW-1:0] m_raw;
      assign sgn[gi]     = opd[gi][W-1];
      assign e_raw[gi]   = opd[gi][W-2 -: EXP_W];
      assign f_raw[gi]   = opd[gi][FRAC_W-1:0];
      assign is_zero[gi] = (e_raw[gi] == '0) && (f_raw[gi] == '0);
      assign is_inf[gi]  = (&e_raw[gi]) && (f_raw[gi] == '0);
      assign is_nan[gi]  = (&e_raw[gi]) && (f_raw[gi] != '0);
      assign is_snan[gi] = is_nan[gi] && !f_raw[gi][FRAC_W-1];
      assign m_raw       = {|e_raw[gi], f_raw[gi]};
      assign lz[gi]      = lzc(m_raw);
      assign m_norm[gi]  = m_raw << lz[gi];
      assign e_eff[gi]   = $signed({2'b00, (e_raw[gi] == '0) ? EXP_W'(1) : e_raw[gi]})
                         - $signed(EW'(lz[gi]));
    end
  endgenerate

  logic signed [EW-1:0] exp_q;
  logic                 pre_shift;
  logic                 res_sign;
  logic                 spec_hit;
  logic [W-1:0]         spec_res;
  logic [4:0]           spec_flags;

  assign exp_q     = e_eff[0] - e_eff[1] + $signed(EW'(BIAS));
  assign pre_shift = m_norm[0] < m_norm[1];
  assign res_sign  = sgn[0] ^ sgn[1];

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = QNAN;
    spec_flags = 5'b00000;
    if (rm_reg > 3'd4) begin
      spec_flags = 5'b10000;
    end else if (is_nan[0] || is_nan[1]) begin
      spec_flags = {is_snan[0] | is_snan[1], 4'b0000};
    end else if ((is_zero[0] && is_zero[1]) || (is_inf[0] && is_inf[1])) begin
      spec_flags = 5'b10000;
    end else if (is_zero[1]) begin
      spec_res   = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      spec_flags = 5'b01000;
    end else if (is_inf[0]) begin
      spec_res   = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (is_inf[1] || is_zero[0]) begin
      spec_res   = {res_sign, {(W-1){1'b0}}};
    end else begin
      spec_hit   = 1'b0;
    end
  end

  // Restoring step: remainder stays below 2*mb, so RW bits suffice.
  logic          q_bit;
  logic [RW-1:0] diff, rem_nxt;
  assign q_bit   = rem_reg >= {1'b0, mb_reg};
  assign diff    = q_bit ? rem_reg - {1'b0, mb_reg} : rem_reg;
  assign rem_nxt = diff << 1;

  logic                 tiny, g_bit, r_bit, s_bit, inexact, inc, ovf, to_inf;
  logic signed [EW-1:0] sh_full, e_fin;
  logic [CW-1:0]        shamt;
  logic [2*QW-1:0]      ext;
  logic [MW-1:0]        mant;
  logic [MW:0]          mant_r;
  logic [W-1:0]         round_res;
  logic [4:0]           round_flags;

  always_comb begin
    tiny    = exp_reg <= $signed(EW'(0));
    sh_full = $signed(EW'(1)) - exp_reg;
    if (!tiny)                             shamt = '0;
    else if (sh_full > $signed(EW'(QW)))   shamt = CW'(QW);
    else                                   shamt = sh_full[CW-1:0];
    ext     = {q_reg, {QW{1'b0}}} >> shamt;
    mant    = ext[2*QW-1 -: MW];
    g_bit   = ext[QW+1];
    r_bit   = ext[QW];
    s_bit   = (|rem_reg) | (|ext[QW-1:0]);
    inexact = g_bit | r_bit | s_bit;
    case (rm_reg)
      3'd0:    inc = g_bit & (r_bit | s_bit | mant[0]);
      3'd2:    inc = inexact & sign_reg;
      3'd3:    inc = inexact & ~sign_reg;
      3'd4:    inc = g_bit;
      default: inc = 1'b0;
    endcase
    mant_r = {1'b0, mant} + {{MW{1'b0}}, inc};
    // A subnormal that rounds up into the hidden bit becomes the minimum normal.
    if (tiny) e_fin = $signed({{(EW-1){1'b0}}, mant_r[MW-1]});
    else      e_fin = exp_reg + $signed({{(EW-1){1'b0}}, mant_r[MW]});
    ovf = e_fin >= $signed(EW'(EMAX));
    case (rm_reg)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = sign_reg;
      3'd3:    to_inf = ~sign_reg;
      default: to_inf = 1'b1;
    endcase
    if (ovf) begin
      round_res   = to_inf ? {sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                           : {sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
      round_flags = 5'b00101;
    end else begin
      round_res   = {sign_reg, e_fin[EXP_W-1:0], mant_r[FRAC_W-1:0]};
      round_flags = {3'b000, tiny & inexact, inexact};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      rm_reg     <= '0;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mb_reg     <= '0;
      rem_reg    <= '0;
      q_reg      <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg  <= op_a;
            b_reg  <= op_b;
            rm_reg <= rm;
            state  <= S_PREP;
          end
        end
        S_PREP: begin
          sign_reg <= res_sign;
          cnt_reg  <= '0;
          q_reg    <= '0;
          mb_reg   <= m_norm[1];
          rem_reg  <= pre_shift ? {m_norm[0], 1'b0} : {1'b0, m_norm[0]};
          exp_reg  <= pre_shift ? exp_q - $signed(EW'(1)) : exp_q;
          if (spec_hit) begin
            result_reg <= spec_res;
            flags_reg  <= spec_flags;
            state      <= S_DONE;
          end else begin
            state      <= S_DIV;
          end
        end
        S_DIV: begin
          rem_reg <= rem_nxt;
          q_reg   <= {q_reg[QW-2:0], q_bit};
          if (cnt_reg == CW'(QW - 1)) state <= S_ROUND;
          else                        cnt_reg <= cnt_reg + CW'(1);
        end
        S_ROUND: begin
          result_reg <= round_res;
          flags_reg  <= round_flags;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule
